// File: rtl/lcd_window_scanner.sv
// lcd_window_scanner: LCD sync/DE timing plus scaled RAM window composited over an x+y background; define LCD_SCAN_BORDER_EN for a white 1-pixel window border
module lcd_window_scanner #(
  parameter int H_ACTIVE   = 480,
  parameter int H_BP       = 43,
  parameter int H_FP       = 8,
  parameter int H_PULSE    = 4,
  parameter int V_ACTIVE   = 272,
  parameter int V_BP       = 12,
  parameter int V_FP       = 8,
  parameter int V_PULSE    = 4,
  parameter int WIN_LOG2   = 6,
  parameter int SCALE_LOG2 = 2,
  parameter int RD_LATENCY = 1,
  parameter int WIN_X0     = 160,
  parameter int WIN_Y0     = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           win_x,
  input  logic [15:0]           win_y,
  output logic                  rd_en,
  output logic [2*WIN_LOG2-1:0] rd_addr,
  input  logic [15:0]           rd_data,
  output logic                  lcd_hsync_n,
  output logic                  lcd_vsync_n,
  output logic                  lcd_de,
  output logic [15:0]           lcd_rgb,
  output logic                  frame_start
);
  localparam int AW = 2 * WIN_LOG2;
  localparam int PW = 21;
  localparam logic [15:0] HT_M1 = 16'(H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] VT_M1 = 16'(V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [15:0] HB = 16'(H_BP);
  localparam logic [15:0] HE = 16'(H_BP + H_ACTIVE);
  localparam logic [15:0] VB = 16'(V_BP);
  localparam logic [15:0] VE = 16'(V_BP + V_ACTIVE);
  localparam logic [15:0] HP = 16'(H_PULSE);
  localparam logic [15:0] VP = 16'(V_PULSE);
  localparam logic [16:0] SPAN = 17'(2 ** (WIN_LOG2 + SCALE_LOG2));
  // pipeline word: {frame_start, hsync_n, vsync_n, de, in_window, background}
  localparam logic [PW-1:0] IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
  logic [15:0]   h_q, h_d, v_q, v_d, ox_q, ox_d, oy_q, oy_d;
  logic [15:0]   x, y, bg;
  logic [16:0]   x17, y17, ox17, oy17;
  logic          act, inwin, border;
  logic [PW-1:0] pipe_q [RD_LATENCY+1];
  logic [PW-1:0] pipe_d [RD_LATENCY+1];
  logic [PW-1:0] last;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_en_q, rd_en_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [15:0]   rgb_q, rgb_d;

  assign last = pipe_q[RD_LATENCY];

  always_comb begin
    h_d  = (h_q == HT_M1) ? '0 : h_q + 16'd1;
    v_d  = (h_q != HT_M1) ? v_q : (v_q == VT_M1) ? '0 : v_q + 16'd1;
    ox_d = (h_q == '0 && v_q == '0) ? win_x : ox_q;
    oy_d = (h_q == '0 && v_q == '0) ? win_y : oy_q;
    x    = h_q - HB;
    y    = v_q - VB;
    x17  = {1'b0, x};
    y17  = {1'b0, y};
    ox17 = {1'b0, ox_q};
    oy17 = {1'b0, oy_q};
    act  = h_q >= HB && h_q < HE && v_q >= VB && v_q < VE;
    inwin = act && x17 >= ox17 && x17 < ox17 + SPAN && y17 >= oy17 && y17 < oy17 + SPAN;
`ifdef LCD_SCAN_BORDER_EN
    border = act && !inwin &&
      (((x17 + 17'd1 == ox17 || x17 == ox17 + SPAN) && y17 + 17'd1 >= oy17 && y17 <= oy17 + SPAN) ||
       ((y17 + 17'd1 == oy17 || y17 == oy17 + SPAN) && x17 + 17'd1 >= ox17 && x17 <= ox17 + SPAN));
`else
    border = 1'b0;
`endif
    bg = act ? x + y : '0;
    rd_en_d   = inwin;
    rd_addr_d = inwin ? {WIN_LOG2'((y - oy_q) >> SCALE_LOG2), WIN_LOG2'((x - ox_q) >> SCALE_LOG2)} : rd_addr_q;
    pipe_d[0] = {h_q == '0 && v_q == '0, h_q >= HP, v_q >= VP, act, inwin, border ? 16'hFFFF : bg};
    for (int i = 1; i <= RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    fs_d  = last[20];
    hs_d  = last[19];
    vs_d  = last[18];
    de_d  = last[17];
    rgb_d = !last[17] ? '0 : last[16] ? rd_data : last[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q       <= '0;
      v_q       <= '0;
      ox_q      <= 16'(WIN_X0);
      oy_q      <= 16'(WIN_Y0);
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) pipe_q[i] <= IDLE;
      fs_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      rgb_q     <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      pipe_q    <= pipe_d;
      fs_q      <= fs_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign frame_start = fs_q;
  assign lcd_hsync_n = hs_q;
  assign lcd_vsync_n = vs_q;
  assign lcd_de      = de_q;
  assign lcd_rgb     = rgb_q;
endmodule
